// File: rtl/scoreboard_register_file.sv
// Register file with per-register busy scoreboard; combinational reads, 1-cycle writes, rsv_ready stalls a reservation while its target is busy.
// Optional same-cycle write-to-read forwarding is enabled by defining REGFILE_BYPASS_EN.
module scoreboard_register_file #(
  parameter int N = 32,
  parameter int A = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_ena,
  input  logic [A-1:0] wr_addr,
  input  logic [N-1:0] wr_data,
  input  logic [A-1:0] rd_addr0,
  input  logic [A-1:0] rd_addr1,
  output logic [N-1:0] rd_data0,
  output logic [N-1:0] rd_data1,
  output logic         rd_busy0,
  output logic         rd_busy1,
  input  logic         rsv_ena,
  input  logic [A-1:0] rsv_addr,
  output logic         rsv_ready,
  output logic [A:0]   busy_count
);

  localparam int R = 1 << A;

  logic [N-1:0] regs [R];
  logic [R-1:0] busy;
  logic         wr_hit;
  logic         rsv_acc;
  logic         wr_clr;

  // x0 is never written or reserved, so its data and busy bit stay at reset values.
  assign wr_hit    = wr_ena && (wr_addr != '0);
  assign rsv_ready = ~busy[rsv_addr];
  assign rsv_acc   = rsv_ena && rsv_ready && (rsv_addr != '0);
  assign wr_clr    = wr_hit && busy[wr_addr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < R; i++) begin
        regs[i] <= '0;
      end
      busy       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_hit) begin
        regs[wr_addr] <= wr_data;
        busy[wr_addr] <= 1'b0;
      end
      // Reservation is applied after the write so it wins on an address collision.
      if (rsv_acc) begin
        busy[rsv_addr] <= 1'b1;
      end
      if (rsv_acc && !wr_clr && (busy_count != (A+1)'(R - 1))) begin
        busy_count <= busy_count + (A+1)'(1);
      end else if (wr_clr && !rsv_acc && (busy_count != '0)) begin
        busy_count <= busy_count - (A+1)'(1);
      end
    end
  end

`ifdef REGFILE_BYPASS_EN
  logic fwd0;
  logic fwd1;

  // Forwarding is suppressed during reset so reads stay at zero.
  assign fwd0 = wr_hit && !rst && (wr_addr == rd_addr0);
  assign fwd1 = wr_hit && !rst && (wr_addr == rd_addr1);

  always_comb begin
    rd_data0 = fwd0 ? wr_data : regs[rd_addr0];
    rd_data1 = fwd1 ? wr_data : regs[rd_addr1];
    rd_busy0 = fwd0 ? 1'b0 : busy[rd_addr0];
    rd_busy1 = fwd1 ? 1'b0 : busy[rd_addr1];
  end
`else
  always_comb begin
    rd_data0 = regs[rd_addr0];
    rd_data1 = regs[rd_addr1];
    rd_busy0 = busy[rd_addr0];
    rd_busy1 = busy[rd_addr1];
  end
`endif

endmodule

// File: tb/tb_scoreboard_register_file.sv
// Directed self-checking bench for scoreboard_register_file with hand-computed expectations.
module tb_scoreboard_register_file;

  localparam int N = 32;
  localparam int A = 5;

  logic         clk;
  logic         rst;
  logic         wr_ena;
  logic [A-1:0] wr_addr;
  logic [N-1:0] wr_data;
  logic [A-1:0] rd_addr0;
  logic [A-1:0] rd_addr1;
  logic [N-1:0] rd_data0;
  logic [N-1:0] rd_data1;
  logic         rd_busy0;
  logic         rd_busy1;
  logic         rsv_ena;
  logic [A-1:0] rsv_addr;
  logic         rsv_ready;
  logic [A:0]   busy_count;

  int tests;
  int fails;

  scoreboard_register_file #(.N(N), .A(A)) dut (
    .clk        (clk),
    .rst        (rst),
    .wr_ena     (wr_ena),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .rd_addr0   (rd_addr0),
    .rd_addr1   (rd_addr1),
    .rd_data0   (rd_data0),
    .rd_data1   (rd_data1),
    .rd_busy0   (rd_busy0),
    .rd_busy1   (rd_busy1),
    .rsv_ena    (rsv_ena),
    .rsv_addr   (rsv_addr),
    .rsv_ready  (rsv_ready),
    .busy_count (busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_ena  = 1'b0;
    rsv_ena = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); wr_addr = '0; wr_data = '0;
    rd_addr0 = 5'd5; rd_addr1 = 5'd31; rsv_addr = 5'd7;
    step(); step();
    tests++; if (busy_count !== 6'd0) begin fails++; $display("FAIL reset_count got=%0d want=0", busy_count); end
    tests++; if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin fails++; $display("FAIL reset_data got=%h/%h want=0/0", rd_data0, rd_data1); end
    tests++; if (rsv_ready !== 1'b1 || rd_busy0 !== 1'b0) begin fails++; $display("FAIL reset_ready got=%b busy=%b want=1/0", rsv_ready, rd_busy0); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_write_read();
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF;
    step();
    idle(); rd_addr0 = 5'd5; rd_addr1 = 5'd5;
    #1;
    tests++; if (rd_data0 !== 32'hDEADBEEF || rd_data1 !== 32'hDEADBEEF) begin fails++; $display("FAIL wr_rd_data got=%h/%h want=deadbeef", rd_data0, rd_data1); end
    tests++; if (rd_busy0 !== 1'b0 || rd_busy1 !== 1'b0 || busy_count !== 6'd0) begin fails++; $display("FAIL wr_rd_busy got=%b%b cnt=%0d want=00 cnt=0", rd_busy0, rd_busy1, busy_count); end
  endtask

  task automatic test_x0();
    wr_ena = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678;
    rsv_ena = 1'b1; rsv_addr = 5'd0;
    #1;
    tests++; if (rsv_ready !== 1'b1) begin fails++; $display("FAIL x0_ready_pre got=%b want=1", rsv_ready); end
    step();
    idle(); rd_addr0 = 5'd0;
    #1;
    tests++; if (rd_data0 !== 32'd0 || rd_busy0 !== 1'b0) begin fails++; $display("FAIL x0_read got=%h busy=%b want=0/0", rd_data0, rd_busy0); end
    tests++; if (busy_count !== 6'd0 || rsv_ready !== 1'b1) begin fails++; $display("FAIL x0_count got=%0d ready=%b want=0/1", busy_count, rsv_ready); end
  endtask

  task automatic test_reserve_conflict();
    rsv_ena = 1'b1; rsv_addr = 5'd7;
    step();
    tests++; if (busy_count !== 6'd1 || rsv_ready !== 1'b0) begin fails++; $display("FAIL rsv7_first got cnt=%0d ready=%b want=1/0", busy_count, rsv_ready); end
    step();
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL rsv7_retry got=%0d want=1", busy_count); end
    idle(); wr_ena = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5;
    step();
    idle(); rd_addr0 = 5'd7;
    #1;
    tests++; if (busy_count !== 6'd0 || rsv_ready !== 1'b1) begin fails++; $display("FAIL wr7_clear got cnt=%0d ready=%b want=0/1", busy_count, rsv_ready); end
    tests++; if (rd_data0 !== 32'hA5 || rd_busy0 !== 1'b0) begin fails++; $display("FAIL wr7_data got=%h busy=%b want=a5/0", rd_data0, rd_busy0); end
  endtask

  task automatic test_simul_diff();
    rsv_ena = 1'b1; rsv_addr = 5'd9;
    step();
    rsv_addr = 5'd3; wr_ena = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    step();
    idle(); rd_addr0 = 5'd3; rd_addr1 = 5'd9;
    #1;
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL simul_diff_count got=%0d want=1", busy_count); end
    tests++; if (rd_busy0 !== 1'b1 || rd_busy1 !== 1'b0 || rd_data1 !== 32'h99) begin fails++; $display("FAIL simul_diff_bits got x3=%b x9=%b d9=%h want 1/0/99", rd_busy0, rd_busy1, rd_data1); end
    wr_ena = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    step();
    idle();
    tests++; if (busy_count !== 6'd0 || rd_busy0 !== 1'b0) begin fails++; $display("FAIL simul_diff_cleanup got cnt=%0d busy=%b want=0/0", busy_count, rd_busy0); end
  endtask

  task automatic test_simul_same();
    wr_ena = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    rsv_ena = 1'b1; rsv_addr = 5'd4;
    step();
    idle(); rd_addr0 = 5'd4;
    #1;
    tests++; if (rd_data0 !== 32'h55 || rd_busy0 !== 1'b1) begin fails++; $display("FAIL simul_same got=%h busy=%b want=55/1", rd_data0, rd_busy0); end
    tests++; if (busy_count !== 6'd1) begin fails++; $display("FAIL simul_same_count got=%0d want=1", busy_count); end
  endtask

  task automatic test_bypass();
    rd_addr1 = 5'd6;
    wr_ena = 1'b1; wr_addr = 5'd6; wr_data = 32'h77;
    #1;
`ifdef REGFILE_BYPASS_EN
    tests++; if (rd_data1 !== 32'h77 || rd_busy1 !== 1'b0) begin fails++; $display("FAIL bypass_fwd got=%h busy=%b want=77/0", rd_data1, rd_busy1); end
`else
    tests++; if (rd_data1 !== 32'd0) begin fails++; $display("FAIL bypass_none got=%h want=0", rd_data1); end
`endif
    step();
    idle();
    tests++; if (rd_data1 !== 32'h77) begin fails++; $display("FAIL bypass_after got=%h want=77", rd_data1); end
  endtask

  task automatic test_async_reset();
    rsv_ena = 1'b1;
    rsv_addr = 5'd1; step();
    rsv_addr = 5'd2; step();
    rsv_addr = 5'd10; step();
    idle();
    tests++; if (busy_count !== 6'd4) begin fails++; $display("FAIL pre_reset_count got=%0d want=4", busy_count); end
    #2;
    rd_addr0 = 5'd4; rd_addr1 = 5'd5;
    wr_ena = 1'b1; wr_addr = 5'd5; wr_data = 32'hCAFE;
    rst = 1'b1;
    #1;
    tests++; if (busy_count !== 6'd0 || rd_busy0 !== 1'b0 || rsv_ready !== 1'b1) begin fails++; $display("FAIL async_rst_busy got cnt=%0d busy=%b ready=%b want=0/0/1", busy_count, rd_busy0, rsv_ready); end
    tests++; if (rd_data0 !== 32'd0 || rd_data1 !== 32'd0) begin fails++; $display("FAIL async_rst_data got=%h/%h want=0/0", rd_data0, rd_data1); end
    step();
    tests++; if (rd_data1 !== 32'd0) begin fails++; $display("FAIL rst_write_drop got=%h want=0", rd_data1); end
    idle(); rst = 1'b0;
    rd_addr0 = 5'd10;
    step();
    tests++; if (rd_busy0 !== 1'b0 || busy_count !== 6'd0 || rd_data1 !== 32'd0) begin fails++; $display("FAIL post_rst got busy=%b cnt=%0d d5=%h want=0/0/0", rd_busy0, busy_count, rd_data1); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_write_read();
    test_x0();
    test_reserve_conflict();
    test_simul_diff();
    test_simul_same();
    test_bypass();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
SCOREBOARD_REGISTER_FILE -- requirements
Module: scoreboard_register_file

Interface
REQ-001 Parameter N, default 32: register data width in bits.
REQ-002 Parameter A, default 5: address width; the file has 2^A registers, x0 through x(2^A-1).
REQ-003 clk  input  1: single clock; all state updates occur on its rising edge.
REQ-004 rst  input  1: reset, asynchronous and active-high.
REQ-005 wr_ena  input  1: write-back enable.
REQ-006 wr_addr  input  A: write-back register address.
REQ-007 wr_data  input  N: write-back data.
REQ-008 rd_addr0, rd_addr1  input  A each: read port addresses.
REQ-009 rd_data0, rd_data1  output  N each: combinational read data.
REQ-010 rd_busy0, rd_busy1  output  1 each: addressed register has a pending write.
REQ-011 rsv_ena  input  1: request to reserve a destination register.
REQ-012 rsv_addr  input  A: destination register to reserve.
REQ-013 rsv_ready  output  1: reservation is accepted this cycle.
REQ-014 busy_count  output  A+1: number of registers currently reserved, registered.

Function
REQ-015 x0 SHALL always read 0 and never report busy; writes and reservations to x0 are ignored and do not change busy_count.
REQ-016 Read path SHALL be combinational: rd_dataK = reg[rd_addrK], rd_busyK = busy[rd_addrK].
REQ-017 Write: on a rising edge with wr_ena=1 and wr_addr!=0, reg[wr_addr] SHALL take wr_data and busy[wr_addr] SHALL clear; write latency 1 cycle.
REQ-018 A write to a non-busy register SHALL update the data and leave busy_count unchanged.
REQ-019 rsv_ready SHALL equal ~busy[rsv_addr], combinationally; it is 1 for rsv_addr=0.
REQ-020 Reserve: on a rising edge with rsv_ena=1, rsv_ready=1 and rsv_addr!=0, busy[rsv_addr] SHALL set.
REQ-021 rsv_ena=1 with rsv_ready=0 SHALL have no effect; the requester holds rsv_ena and rsv_addr until accepted.
REQ-022 Simultaneous write and accepted reserve to the same non-zero address: data SHALL be written and busy SHALL end set, because the reservation wins.
REQ-023 Simultaneous write clearing register i and reserve setting register j≠i: both SHALL take effect, and busy_count SHALL be unchanged.
REQ-024 busy_count SHALL change as follows on the edge where the busy bits update:
  - +1 on an accepted reserve alone;
  - -1 on a write clearing a busy register alone;
  - unchanged when both occur.
REQ-025 busy_count SHALL never exceed 2^A-1 and SHALL never underflow.

Reset
REQ-026 While rst=1, asynchronously and regardless of clk:
  - all registers SHALL be 0;
  - all busy bits SHALL be 0;
  - busy_count SHALL be 0.
REQ-027 With rst=1, rd_data0/1 SHALL read 0, rd_busy0/1 SHALL be 0 and rsv_ready SHALL be 1.
REQ-028 Reset asserted mid-operation SHALL discard pending reservations and any same-cycle write.
REQ-029 The first state update SHALL occur on the first rising edge after rst deasserts.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when wr_ena=1, wr_addr!=0 and wr_addr=rd_addrK, then rd_dataK SHALL equal wr_data and rd_busyK SHALL be 0 in the same cycle.
REQ-031 Macro REGFILE_BYPASS_EN undefined: no forwarding; reads reflect state as of the last edge only.

Verification
REQ-032 Reset, then write x5=0xDEADBEEF, then read x5 on both ports -> rd_data0=rd_data1=0xDEADBEEF, rd_busy=0, busy_count=0.
REQ-033 Write x0=0x12345678 and reserve x0 -> rd_data of x0=0, busy_count=0, rsv_ready=1.
REQ-034 Reserve x7, then re-request x7 -> rsv_ready=0 and busy_count stays 1; then write x7=0xA5 -> busy clears, count=0, rsv_ready=1.
REQ-035 Same edge: reserve x3 and write busy x9 -> busy_count unchanged, x3 busy, x9 free.
REQ-036 Same edge: write x4=0x55 and reserve x4 -> x4=0x55 and x4 busy. With REGFILE_BYPASS_EN, write x6=0x77 while reading x6 -> rd_data=0x77 in the same cycle.
REQ-037 Reserve 3 registers, assert rst asynchronously between edges -> busy_count=0, all rd_busy=0, all registers 0 immediately.
